// File: rtl/shift_register_4bit_serial.sv
// Serial-in, parallel-out shift register with a complementary output bus.
// Define SHIFT_REGISTER_4BIT_SERIAL_CE_EN to add the ce shift-enable input.
module shift_register_4bit_serial #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SHIFT_REGISTER_4BIT_SERIAL_CE_EN
  input  logic             ce,
`endif
  input  logic             D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar
);

  if (WIDTH < 2 || WIDTH > 32) begin : gen_width_check
    $error("WIDTH must be in 2..32");
  end

  logic             shift_en;
  logic [WIDTH-1:0] q_reg_d;
  logic [WIDTH-1:0] q_reg_q;

`ifdef SHIFT_REGISTER_4BIT_SERIAL_CE_EN
  assign shift_en = ce;
`else
  assign shift_en = 1'b1;
`endif

  // Newest bit enters at bit 0; the oldest falls off the MSB.
  always_comb begin
    q_reg_d = q_reg_q;
    if (shift_en) begin
      q_reg_d = {q_reg_q[WIDTH-2:0], D};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_reg_q <= '0;
    end else begin
      q_reg_q <= q_reg_d;
    end
  end

  // Qbar is derived from the register, so it can never disagree with Q.
  assign Q    = q_reg_q;
  assign Qbar = ~q_reg_q;

endmodule

// File: tb/tb_shift_register_4bit_serial.sv
// Self-checking bench for shift_register_4bit_serial at WIDTH=4.
// Extra ce checks run when SHIFT_REGISTER_4BIT_SERIAL_CE_EN is defined.
module tb_shift_register_4bit_serial;

  logic       clk;
  logic       rst;
  logic       D;
  logic [3:0] Q;
  logic [3:0] Qbar;
`ifdef SHIFT_REGISTER_4BIT_SERIAL_CE_EN
  logic       ce;
`endif

  int checks;
  int failures;

  shift_register_4bit_serial #(
    .WIDTH(4)
  ) dut (
    .clk (clk),
    .rst (rst),
`ifdef SHIFT_REGISTER_4BIT_SERIAL_CE_EN
    .ce  (ce),
`endif
    .D   (D),
    .Q   (Q),
    .Qbar(Qbar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       d;
    logic [3:0] q;
  } vec_t;

  task automatic check(input string name, input logic [3:0] exp_q);
    checks++;
    if (Q !== exp_q) begin
      failures++;
      $display("FAIL %s: Q actual=%b required=%b", name, Q, exp_q);
    end
    checks++;
    if (Qbar !== ~exp_q) begin
      failures++;
      $display("FAIL %s: Qbar actual=%b required=%b", name, Qbar, ~exp_q);
    end
  endtask

  // Drive inputs, take one rising edge, then compare 1 time unit later.
  task automatic step(input string name, input logic r, input logic d, input logic [3:0] exp_q);
    rst = r;
    D   = d;
    @(posedge clk);
    #1;
    check(name, exp_q);
  endtask

  vec_t       vecs[10];
  logic [3:0] model;
  logic       r_rand;
  logic       d_rand;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    D        = 1'b1;
`ifdef SHIFT_REGISTER_4BIT_SERIAL_CE_EN
    ce       = 1'b1;
`endif

    vecs[0] = '{"reset0",   1'b0, 1'b1, 4'b0000};
    vecs[1] = '{"reset1",   1'b0, 1'b1, 4'b0000};
    vecs[2] = '{"load1",    1'b1, 1'b1, 4'b0001};
    vecs[3] = '{"load2",    1'b1, 1'b0, 4'b0010};
    vecs[4] = '{"load3",    1'b1, 1'b1, 4'b0101};
    vecs[5] = '{"load4",    1'b1, 1'b1, 4'b1011};
    vecs[6] = '{"overflow1", 1'b1, 1'b0, 4'b0110};
    vecs[7] = '{"overflow2", 1'b1, 1'b0, 4'b1100};
    vecs[8] = '{"overflow3", 1'b1, 1'b0, 4'b1000};
    vecs[9] = '{"overflow4", 1'b1, 1'b0, 4'b0000};

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].name, vecs[i].rst, vecs[i].d, vecs[i].q);
    end

    // Reset in the middle of a stream discards everything in flight.
    step("mid_load1", 1'b1, 1'b1, 4'b0001);
    step("mid_load2", 1'b1, 1'b0, 4'b0010);
    step("mid_load3", 1'b1, 1'b1, 4'b0101);
    step("mid_load4", 1'b1, 1'b1, 4'b1011);
    step("mid_reset", 1'b0, 1'b1, 4'b0000);
    step("mid_release", 1'b1, 1'b1, 4'b0001);

    // Random D/rst against a reference shift model.
    model = 4'b0001;
    for (int i = 0; i < 200; i++) begin
      r_rand = ($urandom_range(0, 7) != 0);
      d_rand = 1'($urandom_range(0, 1));
      model  = r_rand ? {model[2:0], d_rand} : 4'b0000;
      step("random", r_rand, d_rand, model);
    end

`ifdef SHIFT_REGISTER_4BIT_SERIAL_CE_EN
    step("ce_reset", 1'b0, 1'b0, 4'b0000);
    step("ce_load1", 1'b1, 1'b1, 4'b0001);
    step("ce_load2", 1'b1, 1'b0, 4'b0010);
    step("ce_load3", 1'b1, 1'b1, 4'b0101);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("ce_hold", 1'b1, 1'b1, 4'b0101);
    end
    ce = 1'b1;
    step("ce_shift", 1'b1, 1'b1, 4'b1011);
    ce = 1'b0;
    step("ce_reset_wins", 1'b0, 1'b1, 4'b0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
